// File: rtl/life_update_engine_if.sv
// Command/status and cell-RAM signals shared by the simulation controller,
// the cell memory and the life update engine.
interface life_update_engine_if #(
  parameter int X_BITS = 6,
  parameter int Y_BITS = 5,
  parameter int AW     = 1 + X_BITS + Y_BITS
);
  logic          start_update;
  logic          clear_grid;
  logic          grid_swap;
  logic          game_busy;
  logic          cur_bank;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          rd_data;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic          wr_data;
  logic [15:0]   gen_count;

  // Master is the controller/RAM side, slave is the engine.
  modport master (
    output start_update, clear_grid, grid_swap, rd_data,
    input  game_busy, cur_bank, rd_en, rd_addr, wr_en, wr_addr, wr_data, gen_count
  );

  modport slave (
    input  start_update, clear_grid, grid_swap, rd_data,
    output game_busy, cur_bank, rd_en, rd_addr, wr_en, wr_addr, wr_data, gen_count
  );
endinterface

// File: rtl/life_update_engine.sv
// Computes one toroidal Game-of-Life generation from the displayed bank of a
// double-buffered cell RAM into the other bank; also clears both banks.
module life_update_engine #(
  parameter int X_BITS = 6,
  parameter int Y_BITS = 5,
  parameter int AW     = 1 + X_BITS + Y_BITS
) (
  input  logic               clk,
  input  logic               rst,
  life_update_engine_if.slave bus
);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_DRAIN, S_WRITE, S_CLEAR} state_t;

  state_t            r_state;
  logic [X_BITS-1:0] r_x;
  logic [Y_BITS-1:0] r_y;
  logic [3:0]        r_k;
  logic [3:0]        r_count;
  logic              r_self;
  logic              r_busy;
  logic              r_bank;
  logic              r_rd_en;
  logic [AW-1:0]     r_rd_addr;
  logic              r_wr_en;
  logic [AW-1:0]     r_wr_addr;
  logic              r_wr_data;
  logic [15:0]       r_gen;

  logic              w_last_x;
  logic              w_last_cell;
  logic [X_BITS-1:0] w_next_x;
  logic [Y_BITS-1:0] w_next_y;
  logic [3:0]        w_count_final;
  logic              w_new_cell;
  logic              w_swap_bank;

  // Neighbour k (row-major 3x3 around the cell); wrap is plain truncation.
  function automatic logic [AW-1:0] nbrAddr(input logic bank,
                                            input logic [Y_BITS-1:0] y,
                                            input logic [X_BITS-1:0] x,
                                            input logic [3:0] k);
    logic [X_BITS-1:0] nx;
    logic [Y_BITS-1:0] ny;
    nx = x;
    ny = y;
    case (k)
      4'd0, 4'd3, 4'd6: nx = x - X_BITS'(1);
      4'd2, 4'd5, 4'd8: nx = x + X_BITS'(1);
      default:          nx = x;
    endcase
    if (k < 4'd3)      ny = y - Y_BITS'(1);
    else if (k > 4'd5) ny = y + Y_BITS'(1);
    return {bank, ny, nx};
  endfunction

  assign w_last_x      = (r_x == '1);
  assign w_last_cell   = w_last_x && (r_y == '1);
  assign w_next_x      = r_x + X_BITS'(1);
  assign w_next_y      = w_last_x ? r_y + Y_BITS'(1) : r_y;
  assign w_count_final = r_count + {3'b000, bus.rd_data};
  assign w_new_cell    = (w_count_final == 4'd3) | (r_self & (w_count_final == 4'd2));
  assign w_swap_bank   = bus.grid_swap ? ~r_bank : r_bank;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_x       <= '0;
      r_y       <= '0;
      r_k       <= '0;
      r_count   <= '0;
      r_self    <= 1'b0;
      r_busy    <= 1'b0;
      r_bank    <= 1'b0;
      r_rd_en   <= 1'b0;
      r_rd_addr <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= 1'b0;
      r_gen     <= '0;
    end else if (bus.clear_grid) begin
      r_state   <= S_CLEAR;
      r_busy    <= 1'b1;
      r_rd_en   <= 1'b0;
      r_wr_en   <= 1'b1;
      r_wr_addr <= '0;
      r_wr_data <= 1'b0;
      r_x       <= '0;
      r_y       <= '0;
      r_k       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_bank <= w_swap_bank;
          if (bus.start_update) begin
            r_state   <= S_READ;
            r_busy    <= 1'b1;
            r_x       <= '0;
            r_y       <= '0;
            r_k       <= '0;
            r_count   <= '0;
            r_self    <= 1'b0;
            r_rd_en   <= 1'b1;
            r_rd_addr <= nbrAddr(w_swap_bank, '0, '0, 4'd0);
          end
        end

        // r_k is the neighbour being issued; the datum arriving now is k-1.
        S_READ: begin
          if (r_k != 4'd0) begin
            if (r_k == 4'd5) r_self  <= bus.rd_data;
            else             r_count <= r_count + {3'b000, bus.rd_data};
          end
          if (r_k == 4'd8) begin
            r_rd_en <= 1'b0;
            r_state <= S_DRAIN;
          end else begin
            r_k       <= r_k + 4'd1;
            r_rd_addr <= nbrAddr(r_bank, r_y, r_x, r_k + 4'd1);
          end
        end

        S_DRAIN: begin
          r_wr_en   <= 1'b1;
          r_wr_addr <= {~r_bank, r_y, r_x};
          r_wr_data <= w_new_cell;
          r_state   <= S_WRITE;
        end

        S_WRITE: begin
          r_wr_en <= 1'b0;
          if (w_last_cell) begin
            r_x     <= '0;
            r_y     <= '0;
            r_gen   <= r_gen + 16'd1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_x       <= w_next_x;
            r_y       <= w_next_y;
            r_k       <= '0;
            r_count   <= '0;
            r_self    <= 1'b0;
            r_rd_en   <= 1'b1;
            r_rd_addr <= nbrAddr(r_bank, w_next_y, w_next_x, 4'd0);
            r_state   <= S_READ;
          end
        end

        S_CLEAR: begin
          if (r_wr_addr == '1) begin
            r_wr_en <= 1'b0;
            r_bank  <= 1'b0;
            r_gen   <= '0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_wr_addr <= r_wr_addr + AW'(1);
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.game_busy = r_busy;
  assign bus.cur_bank  = r_bank;
  assign bus.rd_en     = r_rd_en;
  assign bus.rd_addr   = r_rd_addr;
  assign bus.wr_en     = r_wr_en;
  assign bus.wr_addr   = r_wr_addr;
  assign bus.wr_data   = r_wr_data;
  assign bus.gen_count = r_gen;

endmodule

// File: doc/life_update_engine.md
Name: life_update_engine

Overview:
- Game-engine responder to the simulation controller's start_update / game_busy / grid_swap / clear_grid handshake.
- On start_update it computes one Game-of-Life generation (toroidal wrap) from the current bank of a double-buffered 1-bit cell memory into the other bank.
- It owns the bank select that the VGA reader displays and clears both banks on request.
- Sits between the simulation controller and the external cell RAM (1-cycle synchronous read latency).

Parameters:
X_BITS, 6, log2 of grid width W (W = 2**X_BITS)
Y_BITS, 5, log2 of grid height H (H = 2**Y_BITS)
AW, 1+X_BITS+Y_BITS, cell memory address width, derived; address = {bank, y, x}

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
start_update  in  1  one-cycle pulse: compute next generation
clear_grid  in  1  one-cycle pulse: zero both banks, abort any update
grid_swap  in  1  one-cycle pulse: toggle displayed bank
game_busy  out  1  high while updating or clearing
cur_bank  out  1  bank holding the current/displayed generation
rd_en  out  1  memory read strobe
rd_addr  out  AW  memory read address
rd_data  in  1  read data, valid one cycle after rd_en
wr_en  out  1  memory write strobe
wr_addr  out  AW  memory write address
wr_data  out  1  write data
gen_count  out  16  completed generations since reset/clear, wraps at 0xFFFF->0

Behaviour:
- Reset values:
  - game_busy=0, cur_bank=0, rd_en=0, rd_addr=0, wr_en=0, wr_addr=0, wr_data=0, gen_count=0.
  - State IDLE, x=y=k=0, count=0, self=0.
- All outputs are registered.
- States: IDLE, READ, DRAIN, WRITE, CLEAR.
- IDLE:
  - clear_grid -> CLEAR, with highest priority.
  - Else if grid_swap: cur_bank toggles.
  - Else if start_update: x=y=k=0 -> READ.
  - start_update and grid_swap in the same cycle: toggle applies, and the update reads the new cur_bank.
  - game_busy goes to 1 on the same edge that samples start_update or clear_grid. The controller therefore sees busy=1 on the cycle after its pulse drops.
- READ:
  - Neighbour offsets k=0..8 map to (dy,dx) in row-major order: (-1,-1),(-1,0),(-1,1),(0,-1),(0,0),(0,1),(1,-1),(1,0),(1,1).
  - One read per cycle: rd_en=1, rd_addr={cur_bank, (y+dy) mod H, (x+dx) mod W}. Wrap is native modulo-2^n truncation.
  - rd_data is captured one cycle after issue. Capture for k=4 -> self; other k add to count (4-bit, range 0..8).
  - count and self are cleared at the start of each cell.
  - After k=8 is issued -> DRAIN.
- DRAIN: capture the final datum; rd_en=0.
- WRITE:
  - wr_en=1, wr_addr={~cur_bank, y, x}, wr_data = (count==3) | (self & count==2).
  - Advance x; on x wrap, advance y. After cell (W-1,H-1): gen_count+1, game_busy=0 -> IDLE.
  - Otherwise -> READ.
- Timing: exactly 11 cycles per cell; an update holds game_busy for W*H*11 cycles.
- The engine never writes cur_bank during an update.
- CLEAR:
  - Write wr_data=0 to every address 0..2^AW-1 in ascending order, one per cycle.
  - Then cur_bank=0, gen_count=0, game_busy=0 -> IDLE.
- clear_grid in READ/DRAIN/WRITE aborts the update immediately: no further reads; the CLEAR sweep restarts from address 0 on the next cycle.
- clear_grid during CLEAR restarts the sweep at 0.
- start_update and grid_swap while busy (any non-IDLE state) are ignored.
- Reset mid-operation returns everything to reset values immediately. Memory contents are undefined afterwards.

Test Plan:
- Reset: assert rst mid-update -> all outputs 0, state IDLE; busy stays 0 with no stimulus.
- Blinker (X_BITS=3, Y_BITS=3, RAM model):
  - Stimulus: bank0 cells (x,y)=(2,3),(3,3),(4,3) set; pulse start_update.
  - Busy rises the edge start_update is sampled and stays high for 704 cycles.
  - Bank1 then holds exactly (3,2),(3,3),(3,4); gen_count=1.
  - grid_swap -> cur_bank=1. A second update writes bank0 back to the horizontal blinker.
- Torus wrap: bank0 corners (0,0),(7,0),(0,7),(7,7) set -> after update, bank1 has the same 4 cells only (stable block across both wraps).
- Clear mid-update:
  - Stimulus: clear_grid 100 cycles into an update.
  - No reads after the abort; 128 consecutive zero writes to addresses 0..127.
  - Then busy=0, cur_bank=0, gen_count=0.
- Ignored requests: start_update and grid_swap pulses during an update -> no restart, cur_bank unchanged, total busy time still 704 cycles.
- Controller handshake: connect the simulation controller (timer shortened) and run 3 generations of the blinker -> exactly 3 grid_swap pulses, each after busy falls; cur_bank toggles 0->1->0->1; the blinker alternates correctly.
